// File: rtl/link_word_aligner.sv
// Multi-link word aligner: finds, confirms and monitors the bit rotation that frames
// PATTERN on each channel, emitting aligned words while locked.
module link_word_aligner #(
    parameter int unsigned NLINKS        = 12,
    parameter int unsigned WIDTH         = 8,
    parameter logic [WIDTH-1:0] PATTERN  = 8'hAC,
    parameter logic [WIDTH-1:0] CHECK_MASK = '1,
    parameter int unsigned LOCK_COUNT    = 16,
    parameter int unsigned UNLOCK_ERRORS = 4,
    parameter int unsigned ERR_CNT_WIDTH = 16,
    localparam int unsigned ROTW         = $clog2(WIDTH)
) (
    input  logic                            clk160,
    input  logic                            rstb,
    input  logic [NLINKS*WIDTH-1:0]         in_data,
    input  logic [NLINKS-1:0]               in_valid,
    input  logic [NLINKS-1:0]               enable,
    input  logic                            reset_counters,
    output logic [NLINKS*WIDTH-1:0]         out_data,
    output logic [NLINKS-1:0]               out_valid,
    output logic [NLINKS-1:0]               locked,
    output logic [NLINKS*ROTW-1:0]          rotation,
    output logic [NLINKS*ERR_CNT_WIDTH-1:0] error_count
);

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned XW = $clog2(UNLOCK_ERRORS + 1);
    localparam logic [ROTW-1:0] ROT_LAST   = ROTW'(WIDTH - 1);
    localparam logic [MW-1:0]   MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [XW-1:0]   MISS_LAST  = XW'(UNLOCK_ERRORS - 1);

    typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

    for (genvar i = 0; i < NLINKS; i++) begin : g_ch
        logic [WIDTH-1:0]         word, prev_q, aligned, data_q;
        logic [2*WIDTH-1:0]       shifted;
        logic [ROTW-1:0]          rot_q, rot_d, rot_next;
        state_t                   state_q, state_d;
        logic [MW-1:0]            match_q, match_d;
        logic [XW-1:0]            miss_q, miss_d;
        logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
        logic                     hit, valid_q;

        assign word     = in_data[i*WIDTH +: WIDTH];
        assign shifted  = {prev_q, word} >> rot_q;
        assign aligned  = shifted[WIDTH-1:0];
        assign rot_next = (rot_q == ROT_LAST) ? '0 : rot_q + 1'b1;
        // LOCKED only checks the masked framing bits; acquisition needs the full word.
        assign hit = (state_q == LOCKED) ? (((aligned ^ PATTERN) & CHECK_MASK) == '0)
                                         : (aligned == PATTERN);

        always_comb begin
            state_d = state_q;
            rot_d   = rot_q;
            match_d = match_q;
            miss_d  = miss_q;
            err_d   = err_q;
            if (!enable[i]) begin
                state_d = SEARCH;
                rot_d   = '0;
                match_d = '0;
                miss_d  = '0;
            end else if (in_valid[i]) begin
                case (state_q)
                    SEARCH: begin
                        if (hit) begin
                            if (LOCK_COUNT == 1) begin
                                state_d = LOCKED;
                            end else begin
                                state_d = CONFIRM;
                                match_d = MW'(1);
                            end
                        end else begin
                            rot_d = rot_next;
                        end
                    end
                    CONFIRM: begin
                        if (!hit) begin
                            state_d = SEARCH;
                            match_d = '0;
                            rot_d   = rot_next;
                        end else if (match_q == MATCH_LAST) begin
                            state_d = LOCKED;
                            match_d = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            miss_d = '0;
                        end else begin
                            if (err_q != '1) err_d = err_q + 1'b1;
                            if (miss_q == MISS_LAST) begin
                                state_d = SEARCH;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + 1'b1;
                            end
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end
            if (reset_counters) err_d = '0;
        end

        always_ff @(posedge clk160) begin
            if (!rstb) begin
                state_q <= SEARCH;
                rot_q   <= '0;
                match_q <= '0;
                miss_q  <= '0;
                err_q   <= '0;
                prev_q  <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                state_q <= state_d;
                rot_q   <= rot_d;
                match_q <= match_d;
                miss_q  <= miss_d;
                err_q   <= err_d;
                valid_q <= in_valid[i] && enable[i] && (state_q == LOCKED);
                if (in_valid[i]) begin
                    prev_q <= word;
                    data_q <= aligned;
                end
            end
        end

        assign out_data[i*WIDTH +: WIDTH]                 = data_q;
        assign out_valid[i]                               = valid_q;
        assign locked[i]                                  = (state_q == LOCKED);
        assign rotation[i*ROTW +: ROTW]                   = rot_q;
        assign error_count[i*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = err_q;
    end

endmodule

// File: tb/tb_link_word_aligner.sv
// Directed bench for link_word_aligner: acquisition, unlock/relock, error counting,
// enable and reset behaviour, plus a narrow-counter instance for saturation.
module tb_link_word_aligner;

    localparam int N  = 12;
    localparam int W  = 8;
    localparam int RW = 3;
    localparam int EW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstb;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid, enable;
    logic            reset_counters;
    logic [N*W-1:0]  out_data;
    logic [N-1:0]    out_valid, locked;
    logic [N*RW-1:0] rotation;
    logic [N*EW-1:0] error_count;

    logic [W-1:0]    s_in_data, s_out_data;
    logic            s_in_valid, s_enable, s_reset_counters, s_out_valid, s_locked;
    logic [RW-1:0]   s_rotation;
    logic [3:0]      s_error_count;

    int total = 0;
    int bad   = 0;

    link_word_aligner u_dut (
        .clk160(clk), .rstb(rstb), .in_data(in_data), .in_valid(in_valid),
        .enable(enable), .reset_counters(reset_counters), .out_data(out_data),
        .out_valid(out_valid), .locked(locked), .rotation(rotation),
        .error_count(error_count)
    );

    link_word_aligner #(
        .NLINKS(1), .LOCK_COUNT(1), .UNLOCK_ERRORS(32), .ERR_CNT_WIDTH(4)
    ) u_sat (
        .clk160(clk), .rstb(rstb), .in_data(s_in_data), .in_valid(s_in_valid),
        .enable(s_enable), .reset_counters(s_reset_counters), .out_data(s_out_data),
        .out_valid(s_out_valid), .locked(s_locked), .rotation(s_rotation),
        .error_count(s_error_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [W-1:0] w);
        for (int i = 0; i < N; i++) in_data[i*W +: W] = w;
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] w);
        in_data[ch*W +: W] = w;
    endtask

    function automatic logic [RW-1:0] rot_of(input int ch);
        return rotation[ch*RW +: RW];
    endfunction

    function automatic logic [W-1:0] data_of(input int ch);
        return out_data[ch*W +: W];
    endfunction

    function automatic logic [EW-1:0] err_of(input int ch);
        return error_count[ch*EW +: EW];
    endfunction

    initial begin
        rstb = 1'b0; in_valid = '0; enable = '1; reset_counters = 1'b0; fill(8'h5A);
        s_in_data = '0; s_in_valid = 1'b0; s_enable = 1'b0; s_reset_counters = 1'b0;
        step;
        check("rst_data",   64'(|out_data),    0);
        check("rst_valid",  64'(out_valid),    0);
        check("rst_locked", 64'(locked),       0);
        check("rst_rot",    64'(|rotation),    0);
        check("rst_err",    64'(|error_count), 0);

        // ch1 carries 0xAC rotated left by 5, all others rotated left by 3
        rstb = 1'b1; fill(8'h65); set_ch(1, 8'h95); in_valid = '1;
        for (int n = 1; n <= 20; n++) begin
            if (n == 20) enable[1] = 1'b0;
            step;
            if (n <= 4) check("rot_search", 64'(rot_of(0)), (n < 4) ? n : 3);
            if (n == 18) check("lock_early", 64'(locked[0]), 0);
            if (n == 19) begin
                check("lock_w19",       64'(locked[0]),    1);
                check("valid_w19",      64'(out_valid[0]), 0);
                check("ch1_rot_conf",   64'(rot_of(1)),    5);
                check("ch1_unlocked",   64'(locked[1]),    0);
            end
            if (n == 20) begin
                check("valid_w20",      64'(out_valid[0]), 1);
                check("data_w20",       64'(data_of(0)),   8'hAC);
                check("dis_rot",        64'(rot_of(1)),    0);
                check("dis_locked",     64'(locked[1]),    0);
                check("dis_valid",      64'(out_valid[1]), 0);
                check("ch0_unaffected", 64'(locked[0]),    1);
            end
        end

        in_valid = '0; set_ch(0, 8'h00);
        step;
        check("hold_valid",  64'(out_valid[0]), 0);
        check("hold_data",   64'(data_of(0)),   8'hAC);
        check("hold_locked", 64'(locked[0]),    1);
        check("hold_err",    64'(err_of(0)),    0);

        in_valid = '1; enable[1] = 1'b1;
        for (int n = 21; n <= 24; n++) begin
            set_ch(0, 8'h00);
            step;
            check("err_inc", 64'(err_of(0)), n - 20);
            check("lock_bad", 64'(locked[0]), (n == 24) ? 0 : 1);
            if (n == 24) begin
                check("unlock_valid", 64'(out_valid[0]), 1);
                check("unlock_rot",   64'(rot_of(0)),    3);
            end
        end

        // prev=0x00 spoils the first resumed word, so rotation sweeps round once more
        set_ch(0, 8'h65);
        for (int n = 25; n <= 48; n++) begin
            step;
            if (n == 29) check("rot_wrap", 64'(rot_of(0)), 0);
            if (n == 47) check("relock_early", 64'(locked[0]), 0);
            if (n == 48) begin
                check("relock",     64'(locked[0]), 1);
                check("relock_rot", 64'(rot_of(0)), 3);
            end
        end

        reset_counters = 1'b1;
        step;
        reset_counters = 1'b0;
        check("clr_err", 64'(err_of(0)), 0);

        for (int n = 50; n <= 56; n++) begin
            set_ch(0, (n == 53) ? 8'h65 : 8'h05);
            step;
            if (n == 52) check("err_3", 64'(err_of(0)), 3);
        end
        check("stay_locked", 64'(locked[0]), 1);
        check("err_6",       64'(err_of(0)), 6);

        set_ch(0, 8'h65);
        step;
        check("all_locked", 64'(locked), 12'hFFF);

        rstb = 1'b0;
        step;
        check("mid_rst_data",   64'(|out_data),    0);
        check("mid_rst_valid",  64'(out_valid),    0);
        check("mid_rst_locked", 64'(locked),       0);
        check("mid_rst_rot",    64'(|rotation),    0);
        check("mid_rst_err",    64'(|error_count), 0);
        rstb = 1'b1;
        step;
        check("restart_rot",    64'(rot_of(0)), 1);
        check("restart_locked", 64'(locked[0]), 0);

        in_valid = '0;
        s_enable = 1'b1; s_in_valid = 1'b1; s_in_data = 8'hAC;
        step;
        check("sat_lock1",   64'(s_locked),    1);
        check("sat_valid1",  64'(s_out_valid), 0);
        s_in_data = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            step;
            if (k == 1 || k == 14 || k == 15 || k == 20)
                check("sat_err", 64'(s_error_count), (k < 15) ? k : 15);
        end
        check("sat_locked", 64'(s_locked), 1);
        s_reset_counters = 1'b1;
        step;
        check("clr_priority", 64'(s_error_count), 0);
        s_reset_counters = 1'b0;
        step;
        check("err_after_clr", 64'(s_error_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/link_word_aligner.md
# link_word_aligner

Parametrised multi-link word aligner sitting between the per-link ISERDES deserialisers and the 8-bit AXI-stream outputs of the link I/O layer. It generalises the fixed 8-bit, fixed-count data path to WIDTH-bit words and NLINKS channels. For each channel it finds the bit rotation that frames a known training PATTERN and confirms lock over LOCK_COUNT consecutive words. While locked it keeps monitoring framing bits, counts errors and drops back to search on repeated misframing.

## Interface
- NLINKS, 12: number of independent channels.
- WIDTH, 8: word width in bits (≥2); ROTW = $clog2(WIDTH).
- PATTERN, 8'hAC (WIDTH bits): training/idle word.
- CHECK_MASK, all ones (WIDTH bits): bits compared against PATTERN while LOCKED.
- LOCK_COUNT, 16: consecutive matches required to lock (≥1).
- UNLOCK_ERRORS, 4: consecutive locked-state mismatches that force relock (≥1).
- ERR_CNT_WIDTH, 16: width of each error counter.
- clk160  in  1  single clock; all logic is on its rising edge.
- rstb  in  1  synchronous, active-low reset.
- in_data  in  NLINKS*WIDTH  raw deserialised words; channel i occupies [i*WIDTH +: WIDTH].
- in_valid  in  NLINKS  per-channel word strobe.
- enable  in  NLINKS  per-channel enable; low holds the channel idle.
- reset_counters  in  1  clears all error counters.
- out_data  out  NLINKS*WIDTH  aligned words, registered.
- out_valid  out  NLINKS  aligned-word strobe; high only while LOCKED.
- locked  out  NLINKS  channel is in LOCKED.
- rotation  out  NLINKS*ROTW  current bit rotation per channel.
- error_count  out  NLINKS*ERR_CNT_WIDTH  saturating locked-state mismatch count per channel.

## Operation
- Per channel, keep a register prev holding the last valid word. cat = {prev, in_word} (2*WIDTH bits). aligned = cat[rot+WIDTH-1 : rot]. With rot=0, aligned is in_word.
- prev updates on every in_valid, in every state.
- A match is aligned == PATTERN in SEARCH and CONFIRM. In LOCKED, a match is (aligned & CHECK_MASK) == (PATTERN & CHECK_MASK).
- State machine per channel: SEARCH, CONFIRM, LOCKED. Transitions are evaluated only on cycles where in_valid[i]=1.
  - SEARCH, match: go to CONFIRM with match_cnt=1. If LOCK_COUNT==1, go straight to LOCKED.
  - SEARCH, mismatch: rot ← rot+1, wrapping from WIDTH-1 to 0.
  - CONFIRM, match: match_cnt+1. When the count reaches LOCK_COUNT, go to LOCKED.
  - CONFIRM, mismatch: go to SEARCH, clear match_cnt, rot ← rot+1 (same wrap).
  - LOCKED, match: clear miss_cnt.
  - LOCKED, mismatch: error_count+1, saturating at all ones; miss_cnt+1. When miss_cnt reaches UNLOCK_ERRORS, go to SEARCH with rot unchanged and miss_cnt cleared.
- A change to rot takes effect from the next valid word.
- When enable[i]=0: state is SEARCH, rot=0, match_cnt=0, miss_cnt=0 and out_valid=0. prev still tracks the input. error_count is held.
- reset_counters clears every error_count. It takes priority over an increment in the same cycle, so the counter reads 0 afterwards.
- When in_valid[i]=0: no state change, out_valid[i]=0, and out_data[i] holds its last value.

## Timing
- Reset (rstb=0 at an edge) leaves: out_data=0, out_valid=0, locked=0, rotation=0, error_count=0, prev=0, all states SEARCH, all counters 0. The same applies to a reset arriving mid-lock or mid-search.
- Latency is 1 cycle. On the edge that samples in_valid=1, out_data loads aligned, computed with the pre-edge rot. out_valid loads (state==LOCKED before the edge).
- The word that completes LOCK_COUNT sets locked=1 at that edge, but its out_valid is 0. The first out_valid=1 is for the next valid word.
- The word that triggers unlock has out_valid=1, and locked falls at the same edge.
- rotation and locked are registered state outputs with no additional delay.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Test plan
- WIDTH=8, PATTERN=0xAC, LOCK_COUNT=16; channel 0 driven with 0x65 (0xAC rotated left by 3) on every cycle.
  - Required: rotation steps 0→1→2→3 on words 1–3.
  - Word 4 matches; locked=1 at the edge of word 19.
  - out_valid=1 from word 20 with out_data=0xAC.
- Locked channel, then 4 consecutive words of 0x00.
  - Required: error_count 1→4; locked falls on the 4th bad word; rotation stays 3.
  - 0x65 resumes → relock after 16 words.
- Locked channel with 3 bad words, 1 good word, then 3 bad words.
  - Required: stays locked; error_count=6.
- Error counter with ERR_CNT_WIDTH=4 and 20 mismatches (UNLOCK_ERRORS=32).
  - Required: error_count saturates at 15.
  - reset_counters pulsed in the same cycle as a mismatch → error_count=0.
- Channel 1 held at rotation 5 with enable[1]=0 mid-CONFIRM.
  - Required: next edge shows rotation=0, locked=0, out_valid=0.
  - Channel 0, still locked, is unaffected.
- rstb=0 for one cycle while all 12 channels are locked.
  - Required: all outputs 0 next edge; realignment restarts from rot=0.
